// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM states and default bus widths.
// The peripheral slaves on this bus import the same package.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // A zero timeout still needs a one-bit counter so the port widths stay legal.
  function automatic int ctrWidth(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// Wait-state counter for the ACCESS phase.
// It flags the last allowed wait cycle and saturates instead of wrapping.
module apb_timeout_ctr
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int CW     = ctrWidth(TIMEOUT);
  localparam int TERM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TERM = CW'(TERM_I);
  localparam logic [CW-1:0] MAXV = '1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != MAXV)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_terminal = (TIMEOUT != 0) && (r_cnt == TERM);

endmodule

// File: rtl/apb_master.sv
// APB3 requester: single-beat command/response front end driving SETUP/ACCESS
// transfers, with PSLVERR reporting and a wait-state timeout abort.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_rsp_timeout,
  output logic              o_PSEL,
  output logic              o_PENABLE,
  output logic              o_PWRITE,
  output logic [ADDR_W-1:0] o_PADDR,
  output logic [DATA_W-1:0] o_PWDATA,
  input  logic [DATA_W-1:0] i_PRDATA,
  input  logic              i_PREADY,
  input  logic              i_PSLVERR
);

  apb_state_e        r_state, w_nextState;
  logic              r_psel, w_psel;
  logic              r_penable, w_penable;
  logic              r_pwrite, w_pwrite;
  logic [ADDR_W-1:0] r_paddr, w_paddr;
  logic [DATA_W-1:0] r_pwdata, w_pwdata;
  logic              r_rspValid, w_rspValid;
  logic [DATA_W-1:0] r_rspRdata, w_rspRdata;
  logic              r_rspErr, w_rspErr;
  logic              r_rspTimeout, w_rspTimeout;
  logic              w_ctrClear, w_ctrEnable, w_terminal;

  apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .i_clear   (w_ctrClear),
    .i_enable  (w_ctrEnable),
    .o_terminal(w_terminal)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state      <= IDLE;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_rspValid   <= 1'b0;
      r_rspRdata   <= '0;
      r_rspErr     <= 1'b0;
      r_rspTimeout <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_psel       <= w_psel;
      r_penable    <= w_penable;
      r_pwrite     <= w_pwrite;
      r_paddr      <= w_paddr;
      r_pwdata     <= w_pwdata;
      r_rspValid   <= w_rspValid;
      r_rspRdata   <= w_rspRdata;
      r_rspErr     <= w_rspErr;
      r_rspTimeout <= w_rspTimeout;
    end
  end

  // Bus and response fields hold by default; rsp_valid is a single-cycle pulse.
  always_comb begin
    w_nextState  = r_state;
    w_psel       = r_psel;
    w_penable    = r_penable;
    w_pwrite     = r_pwrite;
    w_paddr      = r_paddr;
    w_pwdata     = r_pwdata;
    w_rspValid   = 1'b0;
    w_rspRdata   = r_rspRdata;
    w_rspErr     = r_rspErr;
    w_rspTimeout = r_rspTimeout;
    w_ctrClear   = 1'b0;
    w_ctrEnable  = 1'b0;
    case (r_state)
      IDLE: begin
        w_ctrClear = 1'b1;
        if (i_cmd_valid) begin
          w_pwrite    = i_cmd_write;
          w_paddr     = i_cmd_addr;
          w_pwdata    = i_cmd_wdata;
          w_psel      = 1'b1;
          w_penable   = 1'b0;
          w_nextState = SETUP;
        end
      end
      SETUP: begin
        w_ctrClear  = 1'b1;
        w_penable   = 1'b1;
        w_nextState = ACCESS;
      end
      ACCESS: begin
        // Completion is checked before the timeout so a late PREADY still wins.
        if (i_PREADY) begin
          w_psel       = 1'b0;
          w_penable    = 1'b0;
          w_rspValid   = 1'b1;
          w_rspErr     = i_PSLVERR;
          w_rspTimeout = 1'b0;
          w_rspRdata   = r_pwrite ? '0 : i_PRDATA;
          w_nextState  = IDLE;
        end else if (w_terminal) begin
          w_psel       = 1'b0;
          w_penable    = 1'b0;
          w_rspValid   = 1'b1;
          w_rspErr     = 1'b1;
          w_rspTimeout = 1'b1;
          w_rspRdata   = '0;
          w_nextState  = IDLE;
        end else begin
          w_ctrEnable = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign o_cmd_ready   = (r_state == IDLE);
  assign o_rsp_valid   = r_rspValid;
  assign o_rsp_rdata   = r_rspRdata;
  assign o_rsp_err     = r_rspErr;
  assign o_rsp_timeout = r_rspTimeout;
  assign o_PSEL        = r_psel;
  assign o_PENABLE     = r_penable;
  assign o_PWRITE      = r_pwrite;
  assign o_PADDR       = r_paddr;
  assign o_PWDATA      = r_pwdata;

endmodule
